fib_seq_checker: RTL and testbench

//   Sequential, width-parametrised Fibonacci membership checker.

---
 rtl/fib_pkg.sv | 12 +
 rtl/fib_seq_checker.sv | 145 ++++++++++++++
 tb/tb_fib_seq_checker.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci membership checker.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } fib_state_e;

    localparam int unsigned FIB_IDX_W_DEFAULT = 6;

endpackage : fib_pkg

// File: rtl/fib_seq_checker.sv
// Sequential Fibonacci membership checker: walks the sequence one term per clock.
// Build option FIB_FLOOR_EN adds the fib_floor output (largest Fibonacci number <= operand).
module fib_seq_checker
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = FIB_IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_fib,
    output logic [IDX_W-1:0] fib_index
`ifdef FIB_FLOOR_EN
    ,
    output logic [WIDTH-1:0] fib_floor
`endif
);

    // One extra bit so the first term past the operand never wraps.
    localparam int unsigned SEQ_W = WIDTH + 1;

    fib_state_e        r_state;
    fib_state_e        w_state_nxt;
    logic [WIDTH-1:0]  r_val;
    logic [WIDTH-1:0]  w_val_nxt;
    logic [SEQ_W-1:0]  r_a;
    logic [SEQ_W-1:0]  w_a_nxt;
    logic [SEQ_W-1:0]  r_b;
    logic [SEQ_W-1:0]  w_b_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_is_fib;
    logic              w_is_fib_nxt;
    logic [IDX_W-1:0]  r_fib_index;
    logic [IDX_W-1:0]  w_fib_index_nxt;
    logic [SEQ_W-1:0]  w_val_ext;
`ifdef FIB_FLOOR_EN
    logic [WIDTH-1:0]  r_fib_floor;
    logic [WIDTH-1:0]  w_fib_floor_nxt;
`endif

    assign w_val_ext = SEQ_W'(r_val);

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt     = r_state;
        w_val_nxt       = r_val;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_idx_nxt       = r_idx;
        w_is_fib_nxt    = r_is_fib;
        w_fib_index_nxt = r_fib_index;
`ifdef FIB_FLOOR_EN
        w_fib_floor_nxt = r_fib_floor;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_val_nxt   = in_value;
                    w_a_nxt     = '0;
                    w_b_nxt     = SEQ_W'(1);
                    w_idx_nxt   = '0;
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (r_a == w_val_ext) begin
                    w_is_fib_nxt    = 1'b1;
                    w_fib_index_nxt = r_idx;
`ifdef FIB_FLOOR_EN
                    w_fib_floor_nxt = WIDTH'(r_a);
`endif
                    w_state_nxt     = DONE;
                end else if (r_a > w_val_ext) begin
                    // Overshoot: b - a recovers the previous term, which is the floor.
                    w_is_fib_nxt    = 1'b0;
                    w_fib_index_nxt = r_idx - IDX_W'(1);
`ifdef FIB_FLOOR_EN
                    w_fib_floor_nxt = WIDTH'(r_b - r_a);
`endif
                    w_state_nxt     = DONE;
                end else begin
                    w_a_nxt   = r_b;
                    w_b_nxt   = r_a + r_b;
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_val       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_is_fib    <= 1'b0;
            r_fib_index <= '0;
`ifdef FIB_FLOOR_EN
            r_fib_floor <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_val       <= w_val_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_idx       <= w_idx_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_is_fib    <= w_is_fib_nxt;
            r_fib_index <= w_fib_index_nxt;
`ifdef FIB_FLOOR_EN
            r_fib_floor <= w_fib_floor_nxt;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign is_fib    = r_is_fib;
    assign fib_index = r_fib_index;
`ifdef FIB_FLOOR_EN
    assign fib_floor = r_fib_floor;
`endif

endmodule : fib_seq_checker

// File: tb/tb_fib_seq_checker.sv
// Self-checking bench for fib_seq_checker (WIDTH=16), against a table-lookup reference.
module tb_fib_seq_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic        is_fib;
    logic [5:0]  fib_index;
`ifdef FIB_FLOOR_EN
    logic [15:0] fib_floor;
`endif

    int checks   = 0;
    int failures = 0;
    longint fibs [0:30];

    fib_seq_checker #(.WIDTH(16), .IDX_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .is_fib    (is_fib),
        .fib_index (fib_index)
`ifdef FIB_FLOOR_EN
        ,
        .fib_floor (fib_floor)
`endif
    );

    always #5 clk = ~clk;

    // Reference: first table entry >= v decides match/miss and the latency.
    function automatic void model(input int unsigned v, output bit f, output int k,
                                  output int unsigned flr, output int lat);
        int j = 0;
        while (fibs[j] < longint'(v)) j++;
        lat = j + 1;
        if (fibs[j] == longint'(v)) begin
            f = 1'b1; k = j; flr = v;
        end else begin
            f = 1'b0; k = j - 1; flr = int'(fibs[j-1]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] v);
        int n = 0;
        bit acc;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_value = v;
        while (n < 50) begin
            acc = in_ready;
            tick();
            n++;
            if (acc) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        in_value = 16'($urandom);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout value=%0d in_ready stayed low", v);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL result_timeout out_valid=%b after %0d cycles", out_valid, lat);
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
        repeat (3) tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (is_fib !== 1'b0 || fib_index !== 6'd0) begin
            failures++; $display("FAIL reset_result got is_fib=%b idx=%0d exp 0/0", is_fib, fib_index);
        end
`ifdef FIB_FLOOR_EN
        checks++;
        if (fib_floor !== 16'd0) begin failures++; $display("FAIL reset_floor got=%0d exp=0", fib_floor); end
`endif
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] v);
        bit f; int k; int unsigned flr; int lat_exp; int lat;
        model(int'(v), f, k, flr, lat_exp);
        start_op(v);
        wait_result(lat);
        checks++;
        if (is_fib !== f) begin failures++; $display("FAIL %s_is_fib v=%0d got=%b exp=%b", tag, v, is_fib, f); end
        checks++;
        if (fib_index !== 6'(k)) begin failures++; $display("FAIL %s_index v=%0d got=%0d exp=%0d", tag, v, fib_index, k); end
        checks++;
        if (lat != lat_exp) begin failures++; $display("FAIL %s_latency v=%0d got=%0d exp=%0d", tag, v, lat, lat_exp); end
`ifdef FIB_FLOOR_EN
        checks++;
        if (fib_floor !== 16'(flr)) begin failures++; $display("FAIL %s_floor v=%0d got=%0d exp=%0d", tag, v, fib_floor, flr); end
`endif
        retire();
    endtask

    task automatic test_directed();
        logic [15:0] vals [9] = '{16'd0, 16'd13, 16'd4, 16'd65535, 16'd1, 16'd2, 16'd3, 16'd21, 16'd46368};
        foreach (vals[i]) run_and_check("directed", vals[i]);
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int i = 0; i < 40; i++) begin
            v = (i % 2 == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
            run_and_check("random", v);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'd4);
        wait_result(lat);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || is_fib !== 1'b0 || fib_index !== 6'd4 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got valid=%b is_fib=%b idx=%0d in_ready=%b exp 1/0/4/0",
                         c, out_valid, is_fib, fib_index, in_ready);
            end
`ifdef FIB_FLOOR_EN
            checks++;
            if (fib_floor !== 16'd3) begin failures++; $display("FAIL bp_floor got=%0d exp=3", fib_floor); end
`endif
            tick();
        end
        retire();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom_range(0, 1000));
            run_and_check("b2b", v);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_bubble got in_ready=%b exp=1", in_ready); end
        end
    endtask

    task automatic test_reset_mid_search();
        bit seen = 1'b0;
        start_op(16'd46368);
        repeat (5) tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rs_searching got in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rs_in_ready_low got=%b exp=0", in_ready); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rs_idle got in_ready=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (seen) begin failures++; $display("FAIL rs_aborted got out_valid=1 exp never"); end
        run_and_check("after_reset", 16'd1);
    endtask

    initial begin
        fibs[0] = 0;
        fibs[1] = 1;
        for (int i = 2; i <= 30; i++) fibs[i] = fibs[i-1] + fibs[i-2];
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fib_seq_checker
